// File: rtl/dma_channel_arbiter.sv
// Round-robin source arbiter and burst sequencer for the four-channel DMA datapath.
// Optional macro DMA_ARB_PRIORITY_EN: source 0 wins arbitration and may cut a burst short.
module dma_channel_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [3:0]       i_req,
    input  logic [7:0]       i_snk_sel,
    input  logic [3:0]       i_snk_ready,
    input  logic             i_xfer_strobe,
    input  logic [3:0]       i_chan_done,
    output logic [3:0]       o_grant,
    output logic             o_grant_valid,
    output logic [1:0]       o_grant_id,
    output logic [3:0]       o_snk_activate,
    output logic [CNT_W-1:0] o_burst_count,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_REL   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] BL   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(BURST_LEN / 2);

    state_e           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       gid_q, gid_d;
    logic [1:0]       snk_q, snk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       elig;
    logic             pick_vld;
    logic [1:0]       pick;
    logic             rel;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            elig[k] = i_req[k] & i_snk_ready[i_snk_sel[2*k +: 2]];
        end
    end

    // Search starts one past the last winner so a busy source cannot starve the others.
    always_comb begin
        logic [1:0] idx;
        pick_vld = 1'b0;
        pick     = last_q;
        idx      = last_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!pick_vld && elig[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
`ifdef DMA_ARB_PRIORITY_EN
        if (elig[0]) begin
            pick_vld = 1'b1;
            pick     = 2'd0;
        end
`endif
    end

    always_comb begin
        cnt_inc = cnt_q;
        if (i_xfer_strobe && (cnt_q < BL)) begin
            cnt_inc = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        rel = (i_xfer_strobe && (cnt_inc == BL))
            || i_chan_done[gid_q]
            || !i_req[gid_q]
            || !i_snk_ready[snk_q]
            || !i_enable;
`ifdef DMA_ARB_PRIORITY_EN
        if (i_req[0] && (gid_q != 2'd0) && (cnt_q >= HALF)) begin
            rel = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 2'd3;
            gid_q   <= 2'd0;
            snk_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            snk_q   <= snk_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        snk_d   = snk_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_enable && pick_vld) begin
                    state_d = S_GRANT;
                    gid_d   = pick;
                    last_d  = pick;
                    snk_d   = i_snk_sel[{pick, 1'b0} +: 2];
                end
            end
            S_GRANT: begin
                cnt_d = cnt_inc;
                if (rel) begin
                    state_d = S_REL;
                end
            end
            S_REL: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_grant        = 4'b0000;
        o_grant_valid  = 1'b0;
        o_grant_id     = 2'd0;
        o_snk_activate = 4'b0000;
        o_burst_count  = cnt_q;
        o_busy         = (state_q != S_IDLE);
        if (state_q == S_GRANT) begin
            o_grant        = 4'b0001 << gid_q;
            o_grant_valid  = 1'b1;
            o_grant_id     = gid_q;
            o_snk_activate = 4'b0001 << snk_q;
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_dma_channel_arbiter;

    localparam int BL   = 16;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_enable;
    logic [3:0]    i_req;
    logic [7:0]    i_snk_sel;
    logic [3:0]    i_snk_ready;
    logic          i_xfer_strobe;
    logic [3:0]    i_chan_done;
    logic [3:0]    o_grant;
    logic          o_grant_valid;
    logic [1:0]    o_grant_id;
    logic [3:0]    o_snk_activate;
    logic [CW-1:0] o_burst_count;
    logic          o_busy;

    int n_vec;
    int n_err;

    // model: 0 idle, 1 grant, 2 release
    int m_st, m_last, m_gid, m_snk, m_cnt;

    always #5 clk = ~clk;

    dma_channel_arbiter #(.BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (i_enable),
        .i_req          (i_req),
        .i_snk_sel      (i_snk_sel),
        .i_snk_ready    (i_snk_ready),
        .i_xfer_strobe  (i_xfer_strobe),
        .i_chan_done    (i_chan_done),
        .o_grant        (o_grant),
        .o_grant_valid  (o_grant_valid),
        .o_grant_id     (o_grant_id),
        .o_snk_activate (o_snk_activate),
        .o_burst_count  (o_burst_count),
        .o_busy         (o_busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_enable      = 1'b0;
        i_req         = 4'b0000;
        i_snk_sel     = 8'hE4;
        i_snk_ready   = 4'b1111;
        i_xfer_strobe = 1'b0;
        i_chan_done   = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    function automatic bit eligible(int k);
        int s;
        s = (int'(i_snk_sel) >> (2 * k)) & 3;
        return i_req[k] && i_snk_ready[s];
    endfunction

    task automatic model_reset();
        m_st = 0; m_last = 3; m_gid = 0; m_snk = 0; m_cnt = 0;
    endtask

    task automatic model_clock();
        bit rel;
        bit found;
        int k;
        if (m_st == 0) begin
            found = 0;
            if (i_enable) begin
`ifdef DMA_ARB_PRIORITY_EN
                if (eligible(0)) begin
                    found = 1; m_gid = 0;
                end
`endif
                for (int j = 1; j <= 4; j++) begin
                    k = (m_last + j) % 4;
                    if (!found && eligible(k)) begin
                        found = 1; m_gid = k;
                    end
                end
            end
            if (found) begin
                m_last = m_gid;
                m_snk  = (int'(i_snk_sel) >> (2 * m_gid)) & 3;
                m_st   = 1;
            end
            m_cnt = 0;
        end else if (m_st == 1) begin
            rel = 0;
`ifdef DMA_ARB_PRIORITY_EN
            if (i_req[0] && m_gid != 0 && m_cnt >= BL / 2) rel = 1;
`endif
            if (i_xfer_strobe && m_cnt < BL) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == BL) rel = 1;
            end
            if (i_chan_done[m_gid] || !i_req[m_gid]
                || !i_snk_ready[m_snk] || !i_enable) rel = 1;
            if (rel) m_st = 2;
        end else begin
            m_cnt = 0;
            m_st  = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        i_enable = 1'b1;
        i_req    = 4'b1111;
        repeat (2) tick();
        n_vec++;
        if ({o_grant, o_grant_valid, o_grant_id, o_snk_activate,
             o_burst_count, o_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got %b/%b/%0d/%b/%0d/%b required all zero",
                     o_grant, o_grant_valid, o_grant_id, o_snk_activate,
                     o_burst_count, o_busy);
        end
        i_enable = 1'b0;
        rst = 1'b1;
        tick();
        n_vec++;
        if ({o_grant_valid, o_busy, o_burst_count} !== '0) begin
            n_err++;
            $display("FAIL reset_idle: got valid=%b busy=%b cnt=%0d required 0",
                     o_grant_valid, o_busy, o_burst_count);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        i_enable = 1'b1;
        i_req    = 4'b0101;
        tick();
        n_vec++;
        if ({o_grant, o_grant_valid, o_grant_id, o_snk_activate, o_burst_count, o_busy}
            !== {4'b0001, 1'b1, 2'd0, 4'b0001, 8'd0, 1'b1}) begin
            n_err++;
            $display("FAIL rr_first_grant: got g=%b id=%0d act=%b cnt=%0d required g=0001 id=0 act=0001 cnt=0",
                     o_grant, o_grant_id, o_snk_activate, o_burst_count);
        end
        i_xfer_strobe = 1'b1;
        repeat (15) tick();
        n_vec++;
        if ({o_grant, o_burst_count} !== {4'b0001, 8'd15}) begin
            n_err++;
            $display("FAIL rr_count15: got g=%b cnt=%0d required g=0001 cnt=15",
                     o_grant, o_burst_count);
        end
        tick();
        i_xfer_strobe = 1'b0;
        n_vec++;
        if ({o_grant, o_grant_valid, o_snk_activate, o_busy, o_burst_count}
            !== {4'b0000, 1'b0, 4'b0000, 1'b1, 8'd16}) begin
            n_err++;
            $display("FAIL rr_burst_release: got g=%b v=%b act=%b busy=%b cnt=%0d required g=0 v=0 act=0 busy=1 cnt=16",
                     o_grant, o_grant_valid, o_snk_activate, o_busy, o_burst_count);
        end
        tick();
        n_vec++;
        if ({o_busy, o_grant_valid, o_burst_count} !== '0) begin
            n_err++;
            $display("FAIL rr_idle_after_release: got busy=%b v=%b cnt=%0d required 0",
                     o_busy, o_grant_valid, o_burst_count);
        end
        tick();
        n_vec++;
        if ({o_grant, o_grant_id, o_snk_activate} !== {4'b0100, 2'd2, 4'b0100}) begin
            n_err++;
            $display("FAIL rr_second_grant: got g=%b id=%0d act=%b required g=0100 id=2 act=0100",
                     o_grant, o_grant_id, o_snk_activate);
        end
    endtask

    task automatic test_chan_done();
        do_reset();
        i_enable = 1'b1;
        i_req    = 4'b0010;
        tick();
        i_xfer_strobe = 1'b1;
        repeat (5) tick();
        i_xfer_strobe = 1'b0;
        n_vec++;
        if ({o_grant, o_burst_count} !== {4'b0010, 8'd5}) begin
            n_err++;
            $display("FAIL done_count5: got g=%b cnt=%0d required g=0010 cnt=5",
                     o_grant, o_burst_count);
        end
        i_chan_done = 4'b0010;
        i_req       = 4'b1010;
        tick();
        i_chan_done = 4'b0000;
        n_vec++;
        if ({o_grant_valid, o_busy, o_burst_count} !== {1'b0, 1'b1, 8'd5}) begin
            n_err++;
            $display("FAIL done_release: got v=%b busy=%b cnt=%0d required v=0 busy=1 cnt=5",
                     o_grant_valid, o_busy, o_burst_count);
        end
        repeat (2) tick();
        n_vec++;
        if ({o_grant, o_grant_id, o_snk_activate} !== {4'b1000, 2'd3, 4'b1000}) begin
            n_err++;
            $display("FAIL done_fair_regrant: got g=%b id=%0d act=%b required g=1000 id=3 act=1000",
                     o_grant, o_grant_id, o_snk_activate);
        end
    endtask

    task automatic test_sink_skip();
        do_reset();
        i_snk_sel   = 8'h84;
        i_snk_ready = 4'b1011;
        i_enable    = 1'b1;
        i_req       = 4'b1010;
        tick();
        n_vec++;
        if ({o_grant, o_snk_activate} !== {4'b0010, 4'b0010}) begin
            n_err++;
            $display("FAIL skip_grant1: got g=%b act=%b required g=0010 act=0010",
                     o_grant, o_snk_activate);
        end
        i_snk_sel = 8'h88;
        repeat (2) tick();
        n_vec++;
        if ({o_grant_valid, o_snk_activate} !== {1'b1, 4'b0010}) begin
            n_err++;
            $display("FAIL skip_sink_latched: got v=%b act=%b required v=1 act=0010",
                     o_grant_valid, o_snk_activate);
        end
        i_snk_sel   = 8'h84;
        i_snk_ready = 4'b1111;
        i_chan_done = 4'b0010;
        tick();
        i_chan_done = 4'b0000;
        repeat (2) tick();
        n_vec++;
        if ({o_grant, o_grant_id, o_snk_activate} !== {4'b1000, 2'd3, 4'b0100}) begin
            n_err++;
            $display("FAIL skip_grant3: got g=%b id=%0d act=%b required g=1000 id=3 act=0100",
                     o_grant, o_grant_id, o_snk_activate);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        i_enable = 1'b1;
        i_req    = 4'b0100;
        tick();
        i_xfer_strobe = 1'b1;
        repeat (7) tick();
        i_xfer_strobe = 1'b0;
        n_vec++;
        if ({o_grant, o_burst_count} !== {4'b0100, 8'd7}) begin
            n_err++;
            $display("FAIL en_count7: got g=%b cnt=%0d required g=0100 cnt=7",
                     o_grant, o_burst_count);
        end
        i_enable = 1'b0;
        tick();
        n_vec++;
        if ({o_grant_valid, o_busy} !== 2'b01) begin
            n_err++;
            $display("FAIL en_release: got v=%b busy=%b required v=0 busy=1",
                     o_grant_valid, o_busy);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({o_grant_valid, o_busy, o_grant} !== '0) begin
                n_err++;
                $display("FAIL en_hold_idle: got v=%b busy=%b g=%b required 0",
                         o_grant_valid, o_busy, o_grant);
            end
        end
        i_enable = 1'b1;
        tick();
        n_vec++;
        if ({o_grant, o_grant_id} !== {4'b0100, 2'd2}) begin
            n_err++;
            $display("FAIL en_regrant: got g=%b id=%0d required g=0100 id=2",
                     o_grant, o_grant_id);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        i_enable = 1'b1;
        i_req    = 4'b0010;
        tick();
        i_xfer_strobe = 1'b1;
        repeat (9) tick();
        i_xfer_strobe = 1'b0;
        n_vec++;
        if ({o_grant_valid, o_burst_count} !== {1'b1, 8'd9}) begin
            n_err++;
            $display("FAIL rstmid_count9: got v=%b cnt=%0d required v=1 cnt=9",
                     o_grant_valid, o_burst_count);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({o_grant, o_grant_valid, o_grant_id, o_snk_activate,
             o_burst_count, o_busy} !== '0) begin
            n_err++;
            $display("FAIL rstmid_async: got g=%b v=%b cnt=%0d busy=%b required all zero",
                     o_grant, o_grant_valid, o_burst_count, o_busy);
        end
        tick();
        rst   = 1'b1;
        i_req = 4'b1111;
        tick();
        n_vec++;
        if ({o_grant, o_grant_id} !== {4'b0001, 2'd0}) begin
            n_err++;
            $display("FAIL rstmid_regrant0: got g=%b id=%0d required g=0001 id=0",
                     o_grant, o_grant_id);
        end
    endtask

    task automatic test_half_burst_preempt();
        do_reset();
        i_enable = 1'b1;
        i_req    = 4'b0100;
        tick();
        i_xfer_strobe = 1'b1;
        repeat (3) tick();
        i_req = 4'b0101;
        repeat (5) tick();
        i_xfer_strobe = 1'b0;
        n_vec++;
        if ({o_grant, o_burst_count} !== {4'b0100, 8'd8}) begin
            n_err++;
            $display("FAIL pre_count8: got g=%b cnt=%0d required g=0100 cnt=8",
                     o_grant, o_burst_count);
        end
        tick();
`ifdef DMA_ARB_PRIORITY_EN
        n_vec++;
        if ({o_grant_valid, o_busy} !== 2'b01) begin
            n_err++;
            $display("FAIL pre_early_release: got v=%b busy=%b required v=0 busy=1",
                     o_grant_valid, o_busy);
        end
        i_req = 4'b1101;
        repeat (2) tick();
        n_vec++;
        if ({o_grant, o_grant_id} !== {4'b0001, 2'd0}) begin
            n_err++;
            $display("FAIL pre_src0_wins: got g=%b id=%0d required g=0001 id=0",
                     o_grant, o_grant_id);
        end
`else
        n_vec++;
        if ({o_grant, o_grant_valid, o_burst_count} !== {4'b0100, 1'b1, 8'd8}) begin
            n_err++;
            $display("FAIL pre_no_early_release: got g=%b v=%b cnt=%0d required g=0100 v=1 cnt=8",
                     o_grant, o_grant_valid, o_burst_count);
        end
`endif
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < 4; k++) begin
            i_req[k]       = ($urandom_range(0, 9) < 8);
            i_snk_ready[k] = ($urandom_range(0, 9) < 9);
            i_chan_done[k] = ($urandom_range(0, 39) == 0);
        end
        i_enable      = ($urandom_range(0, 39) != 0);
        i_xfer_strobe = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 15) == 0) i_snk_sel = 8'($urandom);
    endtask

    task automatic test_random();
        logic [3:0]    e_g, e_act;
        logic          e_v, e_busy;
        logic [1:0]    e_id;
        logic [CW-1:0] e_cnt;
        do_reset();
        model_reset();
        randomize_inputs();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_clock();
            @(negedge clk);
            e_v    = (m_st == 1);
            e_busy = (m_st != 0);
            e_g    = e_v ? 4'(1 << m_gid) : 4'b0000;
            e_id   = e_v ? 2'(m_gid) : 2'd0;
            e_act  = e_v ? 4'(1 << m_snk) : 4'b0000;
            e_cnt  = CW'(m_cnt);
            n_vec++;
            if ({o_grant, o_grant_valid, o_grant_id, o_snk_activate, o_burst_count, o_busy}
                !== {e_g, e_v, e_id, e_act, e_cnt, e_busy}) begin
                n_err++;
                $display("FAIL random_cycle%0d: got g=%b v=%b id=%0d act=%b cnt=%0d busy=%b required g=%b v=%b id=%0d act=%b cnt=%0d busy=%b",
                         c, o_grant, o_grant_valid, o_grant_id, o_snk_activate,
                         o_burst_count, o_busy, e_g, e_v, e_id, e_act, e_cnt, e_busy);
            end
            randomize_inputs();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_round_robin();
        test_chan_done();
        test_sink_skip();
        test_enable_drop();
        test_reset_mid_grant();
        test_half_burst_preempt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
